logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Scheduler that shares one 8-bit logicUnit among four requesters.
- Round-robin arbitration selects one requester at a time.
- The winner's operands and op select are latched and driven onto the logicUnit inputs; the block waits a settle interval, captures D and returns it through a valid/ready response port.
- Sits between requester blocks and the single logicUnit instance.

Parameters:
- WIDTH, 8, operand/result width; must match logicUnit.
- SETTLE_CYC, 1, cycles the latched operands are held before D is captured; legal range 1..15.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  request per requester; held high until that requester's gnt bit pulses.
- a_bus  in  4*WIDTH  operand A per requester; requester i uses bits [i*WIDTH +: WIDTH].
- b_bus  in  4*WIDTH  operand B per requester, same packing as a_bus.
- op_bus  in  8  {s1,s0} per requester; requester i uses bits [2i+1:2i].
- gnt  out  4  one-hot, one-cycle grant pulse.
- lu_a  out  WIDTH  registered operand A to logicUnit.
- lu_b  out  WIDTH  registered operand B to logicUnit.
- lu_s1  out  1  registered select bit 1 to logicUnit.
- lu_s0  out  1  registered select bit 0 to logicUnit.
- lu_d  in  WIDTH  logicUnit result (combinational from lu_a/lu_b/lu_s1/lu_s0).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  captured result.
- rsp_id  out  2  index of the requester that owns rsp_data.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNT_W  number of completed responses, saturating.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, gnt=0, lu_a=0, lu_b=0, lu_s1=0, lu_s0=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, op_count=0, rr pointer=0, settle counter=0.
- Reset asserted mid-operation aborts immediately; the in-flight request is dropped and no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - At the rising edge where req!=0, pick the winner: the first set req bit searching upward from the rr pointer, wrapping 3->0.
  - At that edge: gnt[winner]<=1 for exactly one cycle; lu_a/lu_b/lu_s1/lu_s0 <= the winner's slices; rsp_id<=winner; rr pointer<=(winner+1) mod 4; settle counter<=SETTLE_CYC-1; go to EXEC.
  - req==0: stay in IDLE; all outputs hold.
- EXEC:
  - If settle counter==0: rsp_data<=lu_d, rsp_valid<=1, go to RESP.
  - Otherwise decrement the settle counter.
  - req is ignored; lu_* outputs are held stable.
- RESP:
  - rsp_valid stays high; rsp_data and rsp_id stay stable until rsp_valid&&rsp_ready at an edge.
  - On that handshake edge: rsp_valid<=0, op_count increments (saturating at all ones), go to IDLE.
  - The next grant occurs no earlier than the edge after the return to IDLE, so there is no back-to-back grant.
- lu_* keep their last values after completion; they are not cleared.
- Latency with SETTLE_CYC=1: req sampled at edge 0 -> gnt high in cycle 1 -> rsp_valid high in cycle 2. In general, rsp_valid rises SETTLE_CYC+1 cycles after the req-sampling edge.
- Requester duties: keep req and operands stable until its gnt pulse. A req bit still high after its gnt is treated as a new request when the block next returns to IDLE.
- Simultaneous requests: exactly one grant per transaction, decided purely by the rr pointer. With all four requesting continuously, grant order is 0,1,2,3,0...
- rsp_ready held high in RESP: one cycle of rsp_valid per transaction. rsp_ready outside RESP has no effect.
- gnt is always one-hot or zero.

Test Plan:
Bench model of logicUnit on lu_d: {s1,s0} 00=A&B, 01=A|B, 10=A^B, 11=~A.
- Reset/idle: rst_n low then high, req=0 for 10 cycles -> all outputs 0, busy=0, op_count=0.
- Single op: req[0]=1, A0=8'hF0, B0=8'h14, op0=01 -> gnt=4'b0001 in cycle 1, rsp_valid in cycle 2 with rsp_data=8'hF4 and rsp_id=0; rsp_ready=1 -> op_count=1.
- Round-robin: req=4'b1111 held; ops 00/01/10/11 with A=8'hF0, B=8'h14 -> grants in order 0,1,2,3,0; rsp_data sequence 8'h10, 8'hF4, 8'hE4, 8'h0F.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_data, rsp_id stable; no gnt issued; completion only once rsp_ready=1.
- SETTLE_CYC=3: single request -> lu_* stable for 3 cycles; rsp_valid rises 4 cycles after the req-sampling edge.
- Reset mid-op: rst_n pulled low while in EXEC -> outputs clear asynchronously; no rsp_valid afterwards; op_count=0; the next request is granted with the rr pointer back at 0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Round-robin scheduler sharing one combinational logicUnit among four requesters.
// Latches the winner's operands, waits a settle interval, captures the result and returns it via valid/ready.
module logic_unit_arbiter #(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_bus,
  input  logic [4*WIDTH-1:0] b_bus,
  input  logic [7:0]         op_bus,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   lu_a,
  output logic [WIDTH-1:0]   lu_b,
  output logic               lu_s1,
  output logic               lu_s0,
  input  logic [WIDTH-1:0]   lu_d,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [1:0]         rsp_id,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] lu_a_q, lu_a_d;
  logic [WIDTH-1:0] lu_b_q, lu_b_d;
  logic             lu_s1_q, lu_s1_d;
  logic             lu_s0_q, lu_s0_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]       rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [1:0]       rr_q, rr_d;
  logic [3:0]       settle_q, settle_d;

  logic [WIDTH-1:0] a_arr [4];
  logic [WIDTH-1:0] b_arr [4];
  logic [1:0]       op_arr [4];
  logic [3:0]       req_rot;
  logic [1:0]       win_off;
  logic [1:0]       winner;

  // req_rot[k] is the request k places above the rr pointer, so the lowest set bit wins.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
      localparam logic [1:0] GI = 2'(gi);
      assign a_arr[gi]   = a_bus[gi*WIDTH +: WIDTH];
      assign b_arr[gi]   = b_bus[gi*WIDTH +: WIDTH];
      assign op_arr[gi]  = op_bus[2*gi +: 2];
      assign req_rot[gi] = req[rr_q + GI];
    end
  endgenerate

  always_comb begin
    logic found;
    found   = 1'b0;
    win_off = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!found && req_rot[k]) begin
        win_off = 2'(k);
        found   = 1'b1;
      end
    end
    winner = rr_q + win_off;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = 4'b0000;
    lu_a_d      = lu_a_q;
    lu_b_d      = lu_b_q;
    lu_s1_d     = lu_s1_q;
    lu_s0_d     = lu_s0_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    op_count_d  = op_count_q;
    rr_d        = rr_q;
    settle_d    = settle_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d    = 4'b0001 << winner;
          lu_a_d   = a_arr[winner];
          lu_b_d   = b_arr[winner];
          lu_s1_d  = op_arr[winner][1];
          lu_s0_d  = op_arr[winner][0];
          rsp_id_d = winner;
          rr_d     = winner + 2'd1;
          settle_d = SETTLE_LOAD;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (settle_q == 4'd0) begin
          rsp_data_d  = lu_d;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (op_count_q != {CNT_W{1'b1}}) begin
            op_count_d = op_count_q + 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 4'b0000;
      lu_a_q      <= '0;
      lu_b_q      <= '0;
      lu_s1_q     <= 1'b0;
      lu_s0_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 2'd0;
      op_count_q  <= '0;
      rr_q        <= 2'd0;
      settle_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      lu_a_q      <= lu_a_d;
      lu_b_q      <= lu_b_d;
      lu_s1_q     <= lu_s1_d;
      lu_s0_q     <= lu_s0_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      op_count_q  <= op_count_d;
      rr_q        <= rr_d;
      settle_q    <= settle_d;
    end
  end

  assign gnt       = gnt_q;
  assign lu_a      = lu_a_q;
  assign lu_b      = lu_b_q;
  assign lu_s1     = lu_s1_q;
  assign lu_s0     = lu_s0_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != S_IDLE);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: one instance with SETTLE_CYC=1, one with SETTLE_CYC=3,
// each driving a behavioural logicUnit model on lu_d.
module tb_logic_unit_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, req3;
  logic [31:0] a_bus, b_bus;
  logic [7:0]  op_bus;
  logic        rsp_ready, rsp_ready3;

  logic [3:0]  gnt, gnt3;
  logic [7:0]  lu_a, lu_b, lu_d, lu_a3, lu_b3, lu_d3;
  logic        lu_s1, lu_s0, lu_s13, lu_s03;
  logic        rsp_valid, rsp_valid3;
  logic [7:0]  rsp_data, rsp_data3;
  logic [1:0]  rsp_id, rsp_id3;
  logic        busy, busy3;
  logic [15:0] op_count, op_count3;

  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] lu_model(input logic [7:0] a, input logic [7:0] b,
                                          input logic s1, input logic s0);
    case ({s1, s0})
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign lu_d  = lu_model(lu_a, lu_b, lu_s1, lu_s0);
  assign lu_d3 = lu_model(lu_a3, lu_b3, lu_s13, lu_s03);

  logic_unit_arbiter #(.WIDTH(8), .SETTLE_CYC(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus), .op_bus(op_bus),
    .gnt(gnt), .lu_a(lu_a), .lu_b(lu_b), .lu_s1(lu_s1), .lu_s0(lu_s0), .lu_d(lu_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .op_count(op_count)
  );

  logic_unit_arbiter #(.WIDTH(8), .SETTLE_CYC(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .a_bus(a_bus), .b_bus(b_bus), .op_bus(op_bus),
    .gnt(gnt3), .lu_a(lu_a3), .lu_b(lu_b3), .lu_s1(lu_s13), .lu_s0(lu_s03), .lu_d(lu_d3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_id(rsp_id3),
    .busy(busy3), .op_count(op_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_gnt [5];
  logic [7:0] exp_dat [5];
  logic [1:0] exp_id  [5];

  initial begin
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat = '{8'h10, 8'hF4, 8'hE4, 8'h0F, 8'h10};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n = 1'b0; req = 4'b0; req3 = 4'b0; rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    a_bus = 32'h0; b_bus = 32'h0; op_bus = 8'h0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("rst_gnt", gnt, 4'b0);
    chk("rst_lu", {lu_a, lu_b, 6'b0, lu_s1, lu_s0}, 32'h0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_rsp", {rsp_data, rsp_id}, 10'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", op_count, 16'd0);

    // Single op on requester 0: F0 | 14
    a_bus = 32'hF0F0F0F0; b_bus = 32'h14141414;
    op_bus = {2'b11, 2'b10, 2'b01, 2'b01};
    req = 4'b0001;
    step();
    chk("single_gnt", gnt, 4'b0001);
    chk("single_busy", busy, 1'b1);
    chk("single_lu", {lu_a, lu_b, 6'b0, lu_s1, lu_s0}, {8'hF0, 8'h14, 8'h01});
    chk("single_valid_early", rsp_valid, 1'b0);
    req = 4'b0;
    step();
    chk("single_valid", rsp_valid, 1'b1);
    chk("single_data", rsp_data, 8'hF4);
    chk("single_id", rsp_id, 2'd0);
    chk("single_gnt_drop", gnt, 4'b0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("single_done", rsp_valid, 1'b0);
    chk("single_count", op_count, 16'd1);
    chk("single_idle", busy, 1'b0);

    // Round-robin from a fresh pointer
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    op_bus = {2'b11, 2'b10, 2'b01, 2'b00};
    req = 4'b1111; rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      for (int n = 0; n < 10 && gnt == 4'b0; n++) step();
      chk($sformatf("rr_gnt%0d", t), gnt, exp_gnt[t]);
      for (int n = 0; n < 10 && !rsp_valid; n++) step();
      chk($sformatf("rr_data%0d", t), rsp_data, exp_dat[t]);
      chk($sformatf("rr_id%0d", t), rsp_id, exp_id[t]);
      if (t == 4) req = 4'b0;
      step();
    end
    rsp_ready = 1'b0;
    step();
    chk("rr_count", op_count, 16'd5);
    chk("rr_idle", busy, 1'b0);

    // Backpressure on requester 1 (pointer now 1), requester 0 waiting
    req = 4'b0010;
    step();
    chk("bp_gnt", gnt, 4'b0010);
    req = 4'b0001;
    step();
    chk("bp_valid", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold%0d", i), {rsp_valid, gnt, rsp_id, rsp_data}, {1'b1, 4'b0, 2'd1, 8'hF4});
    end
    chk("bp_count_held", op_count, 16'd5);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_done", rsp_valid, 1'b0);
    chk("bp_count", op_count, 16'd6);
    chk("bp_no_b2b", gnt, 4'b0);
    step();
    chk("bp_next_gnt", gnt, 4'b0001);
    req = 4'b0;
    step();
    chk("bp_next_data", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd0, 8'h10});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_count2", op_count, 16'd7);

    // SETTLE_CYC=3 instance, requester 2: F0 ^ 14
    req3 = 4'b0100;
    step();
    chk("s3_gnt", gnt3, 4'b0100);
    req3 = 4'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("s3_wait%0d", i), {rsp_valid3, lu_a3, lu_b3, lu_s13, lu_s03},
          {1'b0, 8'hF0, 8'h14, 2'b10});
    end
    step();
    chk("s3_valid", rsp_valid3, 1'b1);
    chk("s3_rsp", {rsp_id3, rsp_data3}, {2'd2, 8'hE4});
    rsp_ready3 = 1'b1;
    step();
    rsp_ready3 = 1'b0;
    chk("s3_count", op_count3, 16'd1);

    // Asynchronous reset while requester 1 is in flight (pointer was 1)
    req = 4'b0010;
    step();
    chk("mid_gnt", gnt, 4'b0010);
    req = 4'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_async", {busy, gnt, rsp_valid, lu_a}, 13'h0);
    chk("mid_count", op_count, 16'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid_novalid%0d", i), rsp_valid, 1'b0);
    end
    req = 4'b0101;
    step();
    chk("mid_rr_reset", gnt, 4'b0001);
    req = 4'b0;
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("mid_count_after", op_count, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
